// File: rtl/w_ingress_ctrl.sv
// Write-side ingress: two-entry skid buffer feeding the FIFO write port.
// Optional fill-level tracking is enabled with `define W_INGRESS_LEVEL_EN.
module w_ingress_ctrl #(
  parameter int          DATA_SIZE = 8,
  parameter int          ADDR_SIZE = 4,
  parameter int unsigned AF_THRESH = 14
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 w_full,
  input  logic [ADDR_SIZE:0]   w_gray,
  input  logic [ADDR_SIZE:0]   w_syn_r_gray,
  output logic                 w_inc,
  output logic [DATA_SIZE-1:0] w_data,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 w_almost_full
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] skid_q, skid_d;
  logic                 rdy_q, rdy_d;
  logic                 accept;
  logic                 pop;

  assign accept   = in_valid & rdy_q;
  assign pop      = (state_q != EMPTY) & ~w_full;
  assign w_inc    = pop;
  assign w_data   = head_q;
  assign in_ready = rdy_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = in_data;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is registered, so it already reflects next cycle's occupancy.
    rdy_d = (state_d != TWO);
  end

`ifdef W_INGRESS_LEVEL_EN
  localparam logic [ADDR_SIZE:0] AF_LVL = AF_THRESH[ADDR_SIZE:0];

  function automatic logic [ADDR_SIZE:0] gray2bin(
    input logic [ADDR_SIZE:0] g
  );
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_SIZE:0] w_bin;
  logic [ADDR_SIZE:0] r_bin;
  logic [ADDR_SIZE:0] level_q, level_d;
  logic               af_q, af_d;

  assign w_bin = gray2bin(w_gray);
  assign r_bin = gray2bin(w_syn_r_gray);

  // Modular subtraction handles the wrap when pointer MSBs differ.
  always_comb begin
    level_d = w_bin - r_bin;
    af_d    = (level_d >= AF_LVL);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      af_q    <= af_d;
    end
  end

  assign w_level       = level_q;
  assign w_almost_full = af_q;
`else
  logic unused_ptrs;
  assign unused_ptrs   = ^{w_gray, w_syn_r_gray};
  assign w_level       = '0;
  assign w_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_w_ingress_ctrl.sv
// Directed testbench for w_ingress_ctrl.
// Level checks expect zeros unless W_INGRESS_LEVEL_EN is defined.
module tb_w_ingress_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

`ifdef W_INGRESS_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          w_full;
  logic [AW:0]   w_gray;
  logic [AW:0]   w_syn_r_gray;
  logic          w_inc;
  logic [DW-1:0] w_data;
  logic [AW:0]   w_level;
  logic          w_almost_full;

  int checks = 0;
  int errors = 0;

  always #5 w_clk = ~w_clk;

  w_ingress_ctrl #(
    .DATA_SIZE(DW),
    .ADDR_SIZE(AW),
    .AF_THRESH(14)
  ) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .w_full(w_full),
    .w_gray(w_gray),
    .w_syn_r_gray(w_syn_r_gray),
    .w_inc(w_inc),
    .w_data(w_data),
    .w_level(w_level),
    .w_almost_full(w_almost_full)
  );

  function automatic logic [AW:0] bin2gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    w_rst        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    w_full       = 1'b0;
    w_gray       = '0;
    w_syn_r_gray = '0;
    #2;
    checks++;
    if ({in_ready, w_inc, w_data, w_level, w_almost_full} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b inc=%b data=%h lvl=%0d af=%b want all 0",
               in_ready, w_inc, w_data, w_level, w_almost_full);
    end
  endtask

  task automatic test_first_word();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || w_inc !== 1'b0) begin
      errors++;
      $display("FAIL ready_first_edge: rdy=%b inc=%b want 1 0", in_ready, w_inc);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (w_inc !== 1'b1 || w_data !== 8'hA5) begin
      errors++;
      $display("FAIL first_word: inc=%b data=%h want 1 a5", w_inc, w_data);
    end
    tick();
    checks++;
    if (w_inc !== 1'b0) begin
      errors++;
      $display("FAIL first_drain: inc=%b want 0", w_inc);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (w_inc !== 1'b1 || w_data !== DW'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: inc=%b data=%h rdy=%b want 1 %h 1",
                 i, w_inc, w_data, in_ready, DW'(i));
      end
      in_data = DW'(i + 1);
      if (i == 15) in_valid = 1'b0;
    end
    tick();
    checks++;
    if (w_inc !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: inc=%b want 0", w_inc);
    end
  endtask

  task automatic test_full_stall();
    w_full   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    in_data = 8'h22;
    checks++;
    if (w_inc !== 1'b0 || w_data !== 8'h11 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_one: inc=%b data=%h rdy=%b want 0 11 1",
               w_inc, w_data, in_ready);
    end
    tick();
    in_data = 8'h33;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (w_inc !== 1'b0 || w_data !== 8'h11 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_two_%0d: inc=%b data=%h rdy=%b want 0 11 0",
                 k, w_inc, w_data, in_ready);
      end
      tick();
    end
    w_full = 1'b0;
    #1;
    checks++;
    if (w_inc !== 1'b1 || w_data !== 8'h11) begin
      errors++;
      $display("FAIL drain_11: inc=%b data=%h want 1 11", w_inc, w_data);
    end
    tick();
    checks++;
    if (w_inc !== 1'b1 || w_data !== 8'h22 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_22: inc=%b data=%h rdy=%b want 1 22 1",
               w_inc, w_data, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (w_inc !== 1'b1 || w_data !== 8'h33) begin
      errors++;
      $display("FAIL drain_33: inc=%b data=%h want 1 33", w_inc, w_data);
    end
    tick();
    checks++;
    if (w_inc !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: inc=%b want 0", w_inc);
    end
  endtask

  task automatic test_level();
    int wv[4] = '{14, 3, 20, 13};
    int rv[4] = '{0, 29, 4, 0};
    int lv[4] = '{14, 6, 16, 13};
    bit av[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW:0] exp_l;
    logic        exp_a;
    for (int i = 0; i < 4; i++) begin
      w_gray       = bin2gray(wv[i]);
      w_syn_r_gray = bin2gray(rv[i]);
      tick();
      exp_l = LVL_EN ? lv[i][AW:0] : '0;
      exp_a = LVL_EN ? av[i] : 1'b0;
      checks++;
      if (w_level !== exp_l || w_almost_full !== exp_a) begin
        errors++;
        $display("FAIL level_%0d: lvl=%0d af=%b want %0d %b",
                 i, w_level, w_almost_full, exp_l, exp_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    w_full   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_data = 8'hC3;
    checks++;
    if (in_ready !== 1'b0 || w_data !== 8'hC1) begin
      errors++;
      $display("FAIL mid_fill: rdy=%b data=%h want 0 c1", in_ready, w_data);
    end
    #2;
    w_full   = 1'b0;
    w_rst    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, w_inc, w_data, w_level, w_almost_full} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b inc=%b data=%h lvl=%0d af=%b want all 0",
               in_ready, w_inc, w_data, w_level, w_almost_full);
    end
    @(negedge w_clk);
    w_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (w_inc !== 1'b0 || w_data !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_%0d: inc=%b data=%h want 0 00",
                 k, w_inc, w_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_full_stall();
    test_level();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w_ingress_ctrl.md
W_INGRESS_CTRL -- requirements
Module: w_ingress_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, meaning FIFO address bits (depth 2^ADDR_SIZE).
REQ-003 SHALL have parameter AF_THRESH, default 14, meaning the fill level at or above which w_almost_full asserts.
REQ-004 Ports, in order (name, direction, width, meaning):
- w_clk  input  1  write-domain clock.
- w_rst  input  1  write-domain reset.
- in_data  input  DATA_SIZE  upstream data word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts in_data this cycle.
- w_full  input  1  FIFO full flag from the write-pointer stage.
- w_gray  input  ADDR_SIZE+1  registered write Gray pointer.
- w_syn_r_gray  input  ADDR_SIZE+1  synchronised read Gray pointer.
- w_inc  output  1  write-pointer increment request.
- w_data  output  DATA_SIZE  word to write to FIFO memory.
- w_level  output  ADDR_SIZE+1  FIFO fill level, write-side view.
- w_almost_full  output  1  fill level >= AF_THRESH.
REQ-005 One clock; reset is asynchronous and active-high (w_clk, w_rst).

Function
REQ-006 Block SHALL implement a two-entry skid buffer (head register plus skid register) with states EMPTY, ONE, TWO.
REQ-007 Accept SHALL occur when in_valid & in_ready; pop SHALL occur when w_inc is 1.
REQ-008 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO.
REQ-009 w_inc SHALL equal head_valid & ~w_full (combinational), with head_valid = (state != EMPTY).
REQ-010 w_data SHALL always present the head register.
REQ-011 Transitions:
- EMPTY: accept -> ONE, word loaded into head.
- ONE: accept & pop -> ONE, head reloaded. Accept & ~pop -> TWO, word loaded into skid. ~accept & pop -> EMPTY.
- TWO: pop -> ONE, skid moved to head. Otherwise hold.
REQ-012 Words SHALL leave the block in acceptance order, with no loss or duplication.
REQ-013 Latency from accept in EMPTY to w_inc SHALL be 1 cycle when w_full is 0.
REQ-014 Sustained in_valid with w_full at 0 SHALL give one write per cycle.
REQ-015 While w_full is 1:
- w_inc SHALL be 0.
- The head SHALL hold.
- The buffer SHALL fill to TWO and deassert in_ready.
REQ-016 The block SHALL convert w_gray and w_syn_r_gray to binary (XOR prefix from the MSB).
REQ-017 w_level SHALL be registered as (w_bin - r_bin) modulo 2^(ADDR_SIZE+1), so it wraps correctly when the pointer MSBs differ.
REQ-018 w_almost_full SHALL be registered as (w_level_next >= AF_THRESH).
REQ-019 A full FIFO SHALL read w_level = 2^ADDR_SIZE.

Reset
REQ-020 On w_rst, the following SHALL take effect immediately, without a clock edge:
- state = EMPTY, in_ready = 0, w_inc = 0.
- head and skid registers = 0, w_data = 0.
- w_level = 0, w_almost_full = 0.
REQ-021 in_ready SHALL rise on the first w_clk edge after w_rst deasserts.
REQ-022 Buffered words SHALL be discarded on reset mid-operation.

Configuration
REQ-023 Macro W_INGRESS_LEVEL_EN:
- Defined: the Gray-to-binary logic, w_level and w_almost_full are generated as specified.
- Undefined: w_level and w_almost_full are tied to 0, and no level logic or registers are synthesised.
- The skid buffer is identical in both cases.

Verification
REQ-024 Reset release, in_valid=1, in_data=0xA5, w_full=0 -> in_ready=1 on first edge; w_inc=1 with w_data=0xA5 the cycle after accept.
REQ-025 16 back-to-back words 0x00..0x0F, w_full=0 -> w_inc high for 16 consecutive cycles, in order, in_ready never low.
REQ-026 w_full=1 while three words 0x11, 0x22, 0x33 are offered:
- 0x11 and 0x22 are accepted, then in_ready=0 and 0x33 is held.
- w_inc stays 0 while w_full=1.
- After w_full=0: outputs 0x11, 0x22, 0x33 on consecutive cycles.
REQ-027 With W_INGRESS_LEVEL_EN, w_gray=bin2gray(14), w_syn_r_gray=0 -> w_level=14 and w_almost_full=1.
REQ-028 With W_INGRESS_LEVEL_EN, w_gray=bin2gray(3), w_syn_r_gray=bin2gray(29) -> w_level=6 (wrap) and w_almost_full=0.
REQ-029 w_rst pulsed while in state TWO -> all outputs 0 asynchronously; the old buffered words never appear on w_data with w_inc=1.
